// File: rtl/cosim_trace_pkg.sv
// Shared types for the cosim trace arbiter: the per-event payload and the halt FSM states.
package cosim_trace_pkg;

  localparam int XLEN      = 64;
  localparam int INST_BITS = 32;
  localparam int RD        = 5;

  typedef struct packed {
    logic                 is_trap;
    logic [XLEN-1:0]      pc;
    logic [INST_BITS-1:0] inst;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      mstatus;
    logic                 check;
    logic                 wdata_valid;
    logic [RD-1:0]        wdata_dest;
    logic                 writes_back;
  } trace_event_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } arb_state_t;

endpackage

// File: rtl/cosim_trace_if.sv
// Bundle of the per-hart event inputs, the shared cosim output port and halt control.
interface cosim_trace_if #(
  parameter int NUM_HARTS  = 2,
  parameter int HARTID_LEN = 1
);
  import cosim_trace_pkg::*;

  logic [NUM_HARTS-1:0]           in_valid;
  logic [NUM_HARTS-1:0]           in_ready;
  logic [NUM_HARTS-1:0]           in_is_trap;
  logic [XLEN*NUM_HARTS-1:0]      in_pc;
  logic [INST_BITS*NUM_HARTS-1:0] in_inst;
  logic [XLEN*NUM_HARTS-1:0]      in_wdata;
  logic [XLEN*NUM_HARTS-1:0]      in_mstatus;
  logic [NUM_HARTS-1:0]           in_check;
  logic [NUM_HARTS-1:0]           in_wdata_valid;
  logic [NUM_HARTS-1:0]           in_writes_back;
  logic [RD*NUM_HARTS-1:0]        in_wdata_dest;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_is_trap;
  logic [HARTID_LEN-1:0] out_hartid;
  logic [XLEN-1:0]       out_pc;
  logic [INST_BITS-1:0]  out_inst;
  logic [XLEN-1:0]       out_wdata;
  logic [XLEN-1:0]       out_mstatus;
  logic                  out_check;
  logic                  out_wdata_valid;
  logic [RD-1:0]         out_wdata_dest;
  logic                  out_writes_back;

  logic                  halt_req;
  logic                  halted;
  logic [63:0]           commit_count;

  modport master (
    output in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus,
           in_check, in_wdata_valid, in_writes_back, in_wdata_dest,
           out_ready, halt_req,
    input  in_ready, out_valid, out_is_trap, out_hartid, out_pc, out_inst,
           out_wdata, out_mstatus, out_check, out_wdata_valid,
           out_wdata_dest, out_writes_back, halted, commit_count
  );

  modport slave (
    input  in_valid, in_is_trap, in_pc, in_inst, in_wdata, in_mstatus,
           in_check, in_wdata_valid, in_writes_back, in_wdata_dest,
           out_ready, halt_req,
    output in_ready, out_valid, out_is_trap, out_hartid, out_pc, out_inst,
           out_wdata, out_mstatus, out_check, out_wdata_valid,
           out_wdata_dest, out_writes_back, halted, commit_count
  );

endinterface

// File: rtl/cosim_trace_fifo.sv
// Per-hart event FIFO; head is the oldest entry and is valid whenever empty is low.
module cosim_trace_fifo
  import cosim_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  trace_event_t din,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output trace_event_t head
);

  localparam int AW = $clog2(DEPTH);

  trace_event_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/cosim_trace_arbiter.sv
// Round-robin merge of per-hart commit/trap streams onto one registered cosim port,
// with a halt FSM that stops intake and drains before reporting halted.
//   state  | meaning
//   RUN    | accepting events, arbitrating
//   DRAIN  | intake closed, emptying FIFOs and output stage
//   HALTED | everything empty, halted=1 until halt_req drops
module cosim_trace_arbiter
  import cosim_trace_pkg::*;
#(
  parameter int NUM_HARTS  = 2,
  parameter int HARTID_LEN = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  cosim_trace_if.slave  bus
);

  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  trace_event_t          din  [NUM_HARTS];
  trace_event_t          head [NUM_HARTS];
  logic [NUM_HARTS-1:0]  push, pop, full, empty, ready;
  arb_state_t            state;
  logic [HW-1:0]         rr_ptr, gnt_idx, next_ptr;
  logic                  gnt_found, load_en;
  trace_event_t          out_ev;
  logic                  out_valid, halted;
  logic [HARTID_LEN-1:0] out_hartid;
  logic [63:0]           commit_count;

  assign load_en  = !out_valid || bus.out_ready;
  assign next_ptr = (int'(gnt_idx) == NUM_HARTS - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      din[h].is_trap     = bus.in_is_trap[h];
      din[h].pc          = bus.in_pc[h*XLEN +: XLEN];
      din[h].inst        = bus.in_inst[h*INST_BITS +: INST_BITS];
      din[h].wdata       = bus.in_wdata[h*XLEN +: XLEN];
      din[h].mstatus     = bus.in_mstatus[h*XLEN +: XLEN];
      din[h].check       = bus.in_check[h];
      din[h].wdata_valid = bus.in_wdata_valid[h];
      din[h].wdata_dest  = bus.in_wdata_dest[h*RD +: RD];
      din[h].writes_back = bus.in_writes_back[h];
      // reset gates ready so nothing looks acceptable while reset is held
      ready[h] = reset && (state == RUN) && !full[h];
      push[h]  = bus.in_valid[h] && ready[h];
      pop[h]   = load_en && gnt_found && (gnt_idx == HW'(h));
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!gnt_found && !empty[HW'((int'(rr_ptr) + i) % NUM_HARTS)]) begin
        gnt_found = 1'b1;
        gnt_idx   = HW'((int'(rr_ptr) + i) % NUM_HARTS);
      end
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    cosim_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[h]),
      .din   (din[h]),
      .full  (full[h]),
      .pop   (pop[h]),
      .empty (empty[h]),
      .head  (head[h])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      rr_ptr       <= '0;
      out_valid    <= 1'b0;
      out_ev       <= '0;
      out_hartid   <= '0;
      halted       <= 1'b0;
      commit_count <= '0;
    end else begin
      if (out_valid && bus.out_ready && !out_ev.is_trap)
        commit_count <= commit_count + 64'd1;

      if (load_en) begin
        out_valid <= gnt_found;
        if (gnt_found) begin
          out_ev     <= head[gnt_idx];
          out_hartid <= HARTID_LEN'(gnt_idx);
          rr_ptr     <= next_ptr;
        end
      end

      case (state)
        RUN: begin
          if (bus.halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.halt_req) begin
            state <= RUN;
          end else if ((&empty) && (!out_valid || bus.out_ready)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (!bus.halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.in_ready        = ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_hartid      = out_hartid;
  assign bus.out_is_trap     = out_ev.is_trap;
  assign bus.out_pc          = out_ev.pc;
  assign bus.out_inst        = out_ev.inst;
  assign bus.out_wdata       = out_ev.wdata;
  assign bus.out_mstatus     = out_ev.mstatus;
  assign bus.out_check       = out_ev.check;
  assign bus.out_wdata_valid = out_ev.wdata_valid;
  assign bus.out_wdata_dest  = out_ev.wdata_dest;
  assign bus.out_writes_back = out_ev.writes_back;
  assign bus.halted          = halted;
  assign bus.commit_count    = commit_count;

endmodule

// File: tb/tb_cosim_trace_arbiter.sv
// Bench for cosim_trace_arbiter: per-hart source queues feed the DUT, accepted events
// form the expected stream, and emitted events are checked against it per scenario.
module tb_cosim_trace_arbiter;
  import cosim_trace_pkg::*;

  localparam int NH = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cosim_trace_if #(.NUM_HARTS(NH), .HARTID_LEN(1)) bus ();

  cosim_trace_arbiter #(.NUM_HARTS(NH), .HARTID_LEN(1), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  trace_event_t src_q [NH][$];
  trace_event_t exp_q [NH][$];
  trace_event_t obs_ev [$];
  int           obs_h [$];
  int valid_pct = 100;
  int ordy_pct  = 100;
  int tick_no = 0;
  int last_xfer_tick = -1;

  function automatic trace_event_t rand_ev(bit trap);
    trace_event_t e;
    e.is_trap     = trap;
    e.pc          = {$urandom, $urandom};
    e.inst        = $urandom;
    e.wdata       = {$urandom, $urandom};
    e.mstatus     = {$urandom, $urandom};
    e.check       = 1'($urandom);
    e.wdata_valid = 1'($urandom);
    e.wdata_dest  = 5'($urandom);
    e.writes_back = 1'($urandom);
    return e;
  endfunction

  function automatic trace_event_t out_event();
    trace_event_t e;
    e.is_trap     = bus.out_is_trap;
    e.pc          = bus.out_pc;
    e.inst        = bus.out_inst;
    e.wdata       = bus.out_wdata;
    e.mstatus     = bus.out_mstatus;
    e.check       = bus.out_check;
    e.wdata_valid = bus.out_wdata_valid;
    e.wdata_dest  = bus.out_wdata_dest;
    e.writes_back = bus.out_writes_back;
    return e;
  endfunction

  task automatic drive(input int h, input trace_event_t e);
    bus.in_is_trap[h]                    = e.is_trap;
    bus.in_pc[h*XLEN +: XLEN]            = e.pc;
    bus.in_inst[h*INST_BITS +: INST_BITS] = e.inst;
    bus.in_wdata[h*XLEN +: XLEN]         = e.wdata;
    bus.in_mstatus[h*XLEN +: XLEN]       = e.mstatus;
    bus.in_check[h]                      = e.check;
    bus.in_wdata_valid[h]                = e.wdata_valid;
    bus.in_wdata_dest[h*RD +: RD]        = e.wdata_dest;
    bus.in_writes_back[h]                = e.writes_back;
  endtask

  // One clock: offer source heads, note handshakes, advance to the next falling edge.
  task automatic tick();
    for (int h = 0; h < NH; h++) begin
      if (src_q[h].size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        drive(h, src_q[h][0]);
        bus.in_valid[h] = 1'b1;
      end else begin
        bus.in_valid[h] = 1'b0;
      end
    end
    bus.out_ready = ($urandom_range(0, 99) < ordy_pct);
    #1;
    for (int h = 0; h < NH; h++)
      if (bus.in_valid[h] && bus.in_ready[h]) exp_q[h].push_back(src_q[h].pop_front());
    if (bus.out_valid && bus.out_ready) begin
      obs_ev.push_back(out_event());
      obs_h.push_back(int'(bus.out_hartid));
      last_xfer_tick = tick_no;
    end
    tick_no++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_all();
    for (int h = 0; h < NH; h++) begin
      src_q[h].delete();
      exp_q[h].delete();
    end
    obs_ev.delete();
    obs_h.delete();
    bus.in_valid  = '0;
    bus.halt_req  = 1'b0;
    bus.out_ready = 1'b0;
    valid_pct = 100;
    ordy_pct  = 100;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_all();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    checks++; if (bus.commit_count !== 64'd0) begin errors++; $display("FAIL reset_commit_count got %0d exp 0", bus.commit_count); end
    checks++; if (bus.in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready got %b exp 00", bus.in_ready); end
    checks++; if (bus.out_pc !== 64'd0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 2'b11) begin errors++; $display("FAIL release_in_ready got %b exp 11", bus.in_ready); end
    @(negedge clock);
  endtask

  task automatic test_single();
    trace_event_t e;
    do_reset();
    e = rand_ev(1'b0);
    e.pc = 64'h0000_0000_8000_0000;
    src_q[0].push_back(e);
    tick();
    checks++; if (exp_q[0].size() != 1) begin errors++; $display("FAIL single_accept got %0d exp 1", exp_q[0].size()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_hartid !== 1'b0) begin errors++; $display("FAIL single_hartid got %0d exp 0", bus.out_hartid); end
    checks++; if (out_event() !== e) begin errors++; $display("FAIL single_payload got %h exp %h", out_event(), e); end
    tick();
    checks++; if (bus.commit_count !== 64'd1) begin errors++; $display("FAIL single_commit_count got %0d exp 1", bus.commit_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    trace_event_t e;
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int h = 0; h < NH; h++) src_q[h].push_back(rand_ev(1'b0));
    while (obs_ev.size() < 6 && n < 30) begin tick(); n++; end
    checks++; if (obs_ev.size() != 6) begin errors++; $display("FAIL rr_count got %0d exp 6", obs_ev.size()); end
    for (int i = 0; i < obs_ev.size(); i++) begin
      checks++; if (obs_h[i] != i % 2) begin errors++; $display("FAIL rr_order[%0d] got hart %0d exp %0d", i, obs_h[i], i % 2); end
      e = exp_q[i % 2].pop_front();
      checks++; if (obs_ev[i] !== e) begin errors++; $display("FAIL rr_payload[%0d] got %h exp %h", i, obs_ev[i], e); end
    end
  endtask

  task automatic test_trap_order();
    trace_event_t ev [3];
    int n = 0;
    do_reset();
    ev[0] = rand_ev(1'b0);
    ev[1] = rand_ev(1'b1);
    ev[1].wdata = 64'h8000_0000_0000_0007;
    ev[2] = rand_ev(1'b0);
    for (int i = 0; i < 3; i++) src_q[1].push_back(ev[i]);
    while (obs_ev.size() < 3 && n < 20) begin tick(); n++; end
    checks++; if (obs_ev.size() != 3) begin errors++; $display("FAIL trap_count got %0d exp 3", obs_ev.size()); end
    for (int i = 0; i < obs_ev.size(); i++) begin
      checks++; if (obs_h[i] != 1 || obs_ev[i] !== ev[i]) begin errors++; $display("FAIL trap_order[%0d] got hart %0d %h exp hart 1 %h", i, obs_h[i], obs_ev[i], ev[i]); end
    end
    checks++; if (bus.commit_count !== 64'd2) begin errors++; $display("FAIL trap_commit_count got %0d exp 2", bus.commit_count); end
  endtask

  task automatic test_backpressure();
    trace_event_t first;
    trace_event_t e;
    int n = 0;
    do_reset();
    ordy_pct = 0;
    for (int i = 0; i < 6; i++) src_q[0].push_back(rand_ev(i == 2));
    first = src_q[0][0];
    repeat (8) tick();
    checks++; if (exp_q[0].size() != 5) begin errors++; $display("FAIL bp_accepted got %0d exp 5", exp_q[0].size()); end
    checks++; if (bus.in_ready !== 2'b10) begin errors++; $display("FAIL bp_in_ready got %b exp 10", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || out_event() !== first) begin errors++; $display("FAIL bp_hold got %b %h exp 1 %h", bus.out_valid, out_event(), first); end
    ordy_pct = 100;
    while (obs_ev.size() < 6 && n < 30) begin tick(); n++; end
    checks++; if (obs_ev.size() != 6) begin errors++; $display("FAIL bp_drain_count got %0d exp 6", obs_ev.size()); end
    for (int i = 0; i < obs_ev.size(); i++) begin
      e = exp_q[0].pop_front();
      checks++; if (obs_h[i] != 0 || obs_ev[i] !== e) begin errors++; $display("FAIL bp_order[%0d] got hart %0d %h exp hart 0 %h", i, obs_h[i], obs_ev[i], e); end
    end
    checks++; if (bus.commit_count !== 64'd5) begin errors++; $display("FAIL bp_commit_count got %0d exp 5", bus.commit_count); end
  endtask

  task automatic test_halt();
    trace_event_t extra;
    trace_event_t e;
    int n = 0;
    do_reset();
    ordy_pct = 0;
    for (int h = 0; h < NH; h++) repeat (2) src_q[h].push_back(rand_ev(1'b0));
    repeat (3) tick();
    bus.halt_req = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 2'b00) begin errors++; $display("FAIL halt_in_ready got %b exp 00", bus.in_ready); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", bus.halted); end
    extra = rand_ev(1'b0);
    src_q[0].push_back(extra);
    ordy_pct = 100;
    while (!bus.halted && n < 20) begin tick(); n++; end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_reached got %b exp 1", bus.halted); end
    checks++; if (obs_ev.size() != 4) begin errors++; $display("FAIL halt_drained got %0d exp 4", obs_ev.size()); end
    checks++; if (last_xfer_tick != tick_no - 1) begin errors++; $display("FAIL halt_timing got last transfer tick %0d exp %0d", last_xfer_tick, tick_no - 1); end
    checks++; if (src_q[0].size() != 1 || bus.in_ready !== 2'b00) begin errors++; $display("FAIL halt_closed got pending %0d ready %b exp 1 00", src_q[0].size(), bus.in_ready); end
    bus.halt_req = 1'b0;
    tick();
    checks++; if (bus.halted !== 1'b0 || bus.in_ready !== 2'b11) begin errors++; $display("FAIL unhalt got halted %b ready %b exp 0 11", bus.halted, bus.in_ready); end
    n = 0;
    while (obs_ev.size() < 5 && n < 20) begin tick(); n++; end
    checks++; if (obs_ev.size() != 5) begin errors++; $display("FAIL unhalt_count got %0d exp 5", obs_ev.size()); end
    for (int i = 0; i < obs_ev.size(); i++) begin
      e = exp_q[obs_h[i]].pop_front();
      checks++; if (obs_ev[i] !== e) begin errors++; $display("FAIL halt_payload[%0d] got %h exp %h", i, obs_ev[i], e); end
    end
  endtask

  task automatic test_random();
    int total = 0, ncommit = 0, n = 0, bad_halt = 0, bad_hart = 0;
    trace_event_t e;
    do_reset();
    valid_pct = 60;
    ordy_pct  = 70;
    for (int h = 0; h < NH; h++)
      for (int i = 0; i < 30; i++) begin
        e = rand_ev($urandom_range(0, 4) == 0);
        if (!e.is_trap) ncommit++;
        src_q[h].push_back(e);
        total++;
      end
    while (obs_ev.size() < total && n < 3000) begin
      if ($urandom_range(0, 19) == 0) bus.halt_req = ~bus.halt_req;
      tick();
      if (bus.halted && bus.in_ready != 2'b00) bad_halt++;
      n++;
    end
    bus.halt_req = 1'b0;
    checks++; if (obs_ev.size() != total) begin errors++; $display("FAIL rand_count got %0d exp %0d", obs_ev.size(), total); end
    checks++; if (bad_halt != 0) begin errors++; $display("FAIL rand_halted_ready got %0d cycles exp 0", bad_halt); end
    for (int i = 0; i < obs_ev.size(); i++) begin
      if (obs_h[i] < 0 || obs_h[i] >= NH || exp_q[obs_h[i]].size() == 0) begin
        bad_hart++;
      end else begin
        e = exp_q[obs_h[i]].pop_front();
        checks++; if (obs_ev[i] !== e) begin errors++; $display("FAIL rand_payload[%0d] hart %0d got %h exp %h", i, obs_h[i], obs_ev[i], e); end
      end
    end
    checks++; if (bad_hart != 0) begin errors++; $display("FAIL rand_unexpected got %0d exp 0", bad_hart); end
    checks++; if (bus.commit_count !== 64'(ncommit)) begin errors++; $display("FAIL rand_commit_count got %0d exp %0d", bus.commit_count, ncommit); end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.halt_req = 1'b1;
    repeat (3) tick();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL ar_pre_halted got %b exp 1", bus.halted); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL ar_halted got %b exp 0", bus.halted); end
    @(negedge clock);
    reset = 1'b1;
    clear_all();
    for (int h = 0; h < NH; h++) repeat (4) src_q[h].push_back(rand_ev(1'b0));
    repeat (4) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.commit_count == 64'd0) begin errors++; $display("FAIL ar_pre_burst got valid %b count %0d exp 1 nonzero", bus.out_valid, bus.commit_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.commit_count !== 64'd0) begin errors++; $display("FAIL ar_commit_count got %0d exp 0", bus.commit_count); end
    checks++; if (bus.in_ready !== 2'b00 || bus.out_pc !== 64'd0) begin errors++; $display("FAIL ar_state got ready %b pc %h exp 00 0", bus.in_ready, bus.out_pc); end
    @(negedge clock);
    reset = 1'b1;
    clear_all();
    repeat (6) tick();
    checks++; if (obs_ev.size() != 0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_empty got %0d events valid %b exp 0 0", obs_ev.size(), bus.out_valid); end
  endtask

  initial begin
    bus.in_valid       = '0;
    bus.in_is_trap     = '0;
    bus.in_pc          = '0;
    bus.in_inst        = '0;
    bus.in_wdata       = '0;
    bus.in_mstatus     = '0;
    bus.in_check       = '0;
    bus.in_wdata_valid = '0;
    bus.in_writes_back = '0;
    bus.in_wdata_dest  = '0;
    bus.out_ready      = 1'b0;
    bus.halt_req       = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_round_robin();
    test_trap_order();
    test_backpressure();
    test_halt();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
